// File: rtl/mont_cmd_engine.sv
// Command-driven Montgomery engine: slot register file, modulus register, status word per command.
// MUL takes RSA_BITS+2 cycles accept->status; outputs hold until read. MONT_MOD_CHECK_EN rejects even moduli.
module mont_cmd_engine #(
  parameter int RSA_BITS  = 1024,
  parameter int NUM_SLOTS = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [RSA_BITS-1:0] bram_din,
  input  logic                bram_din_valid,
  output logic [RSA_BITS-1:0] bram_dout,
  output logic                bram_dout_valid,
  input  logic                bram_dout_read,
  input  logic [31:0]         port1_din,
  input  logic                port1_valid,
  output logic                port1_read,
  output logic [31:0]         port2_dout,
  output logic                port2_valid,
  input  logic                port2_read
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(RSA_BITS) + 1;
  localparam logic [4:0]    NS5  = 5'(NUM_SLOTS);
  localparam logic [CW-1:0] LAST = CW'(RSA_BITS - 1);

  localparam logic [3:0] OP_LOAD    = 4'd0;
  localparam logic [3:0] OP_MUL     = 4'd1;
  localparam logic [3:0] OP_STORE   = 4'd2;
  localparam logic [3:0] OP_LOADMOD = 4'd3;

  typedef enum logic [2:0] {
    IDLE, LOAD_WAIT, COMPUTE, FINAL_SUB, STORE_WAIT, STATUS
  } state_t;

  state_t state, state_nxt;

  logic [RSA_BITS-1:0] slot [NUM_SLOTS];
  logic [RSA_BITS-1:0] mod_q, a_q, b_q, dout_q;
  logic [RSA_BITS+1:0] acc_q;
  logic [CW-1:0]       cnt_q;
  logic [3:0]          op_q;
  logic [SW-1:0]       dst_q;
  logic [31:0]         status_q;

  logic [3:0] cmd_op, cmd_dst, cmd_srca, cmd_srcb;
  logic       dst_bad, a_bad, b_bad, mod_bad;
  logic       cmd_err, cmd_skip;
  logic       unused_cmd_bits;

  assign cmd_op   = port1_din[3:0];
  assign cmd_dst  = port1_din[7:4];
  assign cmd_srca = port1_din[11:8];
  assign cmd_srcb = port1_din[15:12];
  assign unused_cmd_bits = ^port1_din[31:16];

  assign dst_bad = ({1'b0, cmd_dst}  >= NS5);
  assign a_bad   = ({1'b0, cmd_srca} >= NS5);
  assign b_bad   = ({1'b0, cmd_srcb} >= NS5);

`ifdef MONT_MOD_CHECK_EN
  assign mod_bad = ~mod_q[0];
`else
  assign mod_bad = 1'b0;
`endif

  // Only the slot fields an opcode actually uses are range-checked.
  always_comb begin
    cmd_err  = 1'b0;
    cmd_skip = 1'b0;
    case (cmd_op)
      OP_LOAD:    cmd_err = dst_bad;
      OP_MUL: begin
        cmd_err  = dst_bad | a_bad | b_bad | mod_bad;
        cmd_skip = ~(dst_bad | a_bad | b_bad) & mod_bad;
      end
      OP_STORE:   cmd_err = a_bad;
      OP_LOADMOD: cmd_err = 1'b0;
      default:    cmd_err = 1'b1;
    endcase
  end

  // Montgomery step: accumulator stays below 4M, so two guard bits suffice.
  logic [RSA_BITS+1:0] acc_add, acc_red, acc_nxt, acc_sub;
  logic [RSA_BITS-1:0] mul_res;
  always_comb begin
    acc_add = acc_q + (a_q[0] ? {2'b00, b_q} : '0);
    acc_red = acc_add + (acc_add[0] ? {2'b00, mod_q} : '0);
    acc_nxt = acc_red >> 1;
    acc_sub = acc_q - {2'b00, mod_q};
    mul_res = (acc_q >= {2'b00, mod_q}) ? acc_sub[RSA_BITS-1:0] : acc_q[RSA_BITS-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    port1_read      = 1'b0;
    bram_dout_valid = 1'b0;
    port2_valid     = 1'b0;
    case (state)
      IDLE: begin
        if (port1_valid && resetn) begin
          port1_read = 1'b1;
          if (cmd_skip)     state_nxt = FINAL_SUB;
          else if (cmd_err) state_nxt = STATUS;
          else begin
            case (cmd_op)
              OP_MUL:   state_nxt = COMPUTE;
              OP_STORE: state_nxt = STORE_WAIT;
              default:  state_nxt = LOAD_WAIT;
            endcase
          end
        end
      end
      LOAD_WAIT:  if (bram_din_valid) state_nxt = STATUS;
      COMPUTE:    if (cnt_q == LAST) state_nxt = FINAL_SUB;
      FINAL_SUB:  state_nxt = STATUS;
      STORE_WAIT: begin
        bram_dout_valid = 1'b1;
        if (bram_dout_read) state_nxt = STATUS;
      end
      STATUS: begin
        port2_valid = 1'b1;
        if (port2_read) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bram_dout  = dout_q;
  assign port2_dout = status_q;

  // Operands are snapshotted at accept so dst may alias either source.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot[i] <= '0;
      mod_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dout_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      dst_q    <= '0;
      status_q <= '0;
    end else begin
      if (port1_read) begin
        op_q     <= cmd_op;
        dst_q    <= cmd_dst[SW-1:0];
        a_q      <= slot[cmd_srca[SW-1:0]];
        b_q      <= slot[cmd_srcb[SW-1:0]];
        acc_q    <= '0;
        cnt_q    <= '0;
        status_q <= {24'h0, cmd_op, 2'b00, cmd_err, 1'b1};
        if (cmd_op == OP_STORE && !cmd_err) dout_q <= slot[cmd_srca[SW-1:0]];
      end
      case (state)
        LOAD_WAIT: begin
          if (bram_din_valid) begin
            if (op_q == OP_LOADMOD) mod_q <= bram_din;
            else                    slot[dst_q] <= bram_din;
          end
        end
        COMPUTE: begin
          acc_q <= acc_nxt;
          a_q   <= a_q >> 1;
          cnt_q <= cnt_q + 1'b1;
        end
        // An error flag here means the even-modulus skip path: leave dst alone.
        FINAL_SUB: if (!status_q[1]) slot[dst_q] <= mul_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_cmd_engine.sv
// Bench for mont_cmd_engine (RSA_BITS=8, NUM_SLOTS=4): scoreboard queues fed by the driver,
// checked by a monitor against an arithmetic Montgomery reference model.
module tb_mont_cmd_engine;
  localparam int N  = 8;
  localparam int NS = 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic [N-1:0] bram_din;
  logic         bram_din_valid;
  logic [N-1:0] bram_dout;
  logic         bram_dout_valid;
  logic         bram_dout_read;
  logic [31:0]  port1_din;
  logic         port1_valid;
  logic         port1_read;
  logic [31:0]  port2_dout;
  logic         port2_valid;
  logic         port2_read;

  mont_cmd_engine #(.RSA_BITS(N), .NUM_SLOTS(NS)) dut (
    .clk(clk), .resetn(resetn),
    .bram_din(bram_din), .bram_din_valid(bram_din_valid),
    .bram_dout(bram_dout), .bram_dout_valid(bram_dout_valid), .bram_dout_read(bram_dout_read),
    .port1_din(port1_din), .port1_valid(port1_valid), .port1_read(port1_read),
    .port2_dout(port2_dout), .port2_valid(port2_valid), .port2_read(port2_read)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int status_seen = 0;
  logic [31:0] exp_st[$];
  int          exp_dout[$];

  int m_slot [NS];
  int m_mod;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Result r in [0,M) with r*2^N == A*B (mod M); unique for odd M.
  function automatic int mont(input int a, input int b, input int m);
    int ab;
    ab = (a * b) % m;
    for (int r = 0; r < m; r++)
      if (((r << N) % m) == ab) return r;
    return -1;
  endfunction

  initial begin
    port2_read = 1'b0;
    bram_dout_read = 1'b0;
    forever begin
      @(posedge clk); #1;
      port2_read     = ($urandom_range(0, 2) != 0);
      bram_dout_read = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (resetn && port2_valid && port2_read) begin
        if (exp_st.size() == 0) begin
          checks++; errors++;
          $display("FAIL status_unexpected: got %h expected none", port2_dout);
        end else begin
          e = exp_st.pop_front();
          chk("status", port2_dout, e);
        end
        status_seen++;
      end
      if (resetn && bram_dout_valid && bram_dout_read) begin
        if (exp_dout.size() == 0) begin
          checks++; errors++;
          $display("FAIL dout_unexpected: got %h expected none", bram_dout);
        end else begin
          e = 32'(exp_dout.pop_front());
          chk("bram_dout", {24'h0, bram_dout}, e);
        end
      end
    end
  end

  task automatic do_cmd(input int op, input int dst, input int sa, input int sb, input int data);
    bit          err, skip, ok;
    int          prior, lat, exp_lat;
    logic [31:0] cmd, upper;
    err  = (op > 3);
    skip = 1'b0;
    if (op == 0 && dst >= NS) err = 1'b1;
    if (op == 1 && (dst >= NS || sa >= NS || sb >= NS)) err = 1'b1;
    if (op == 2 && sa >= NS) err = 1'b1;
`ifdef MONT_MOD_CHECK_EN
    if (op == 1 && !err && (m_mod % 2) == 0) begin err = 1'b1; skip = 1'b1; end
`endif
    exp_lat = -1;
    if (op == 1 && !err) exp_lat = N + 2;
    if (skip) exp_lat = 2;
    exp_st.push_back({24'h0, 4'(op), 2'b00, err, 1'b1});
    if (!err) begin
      case (op)
        0: m_slot[dst] = data;
        3: m_mod = data;
        1: if ((m_mod % 2) == 1) m_slot[dst] = mont(m_slot[sa], m_slot[sb], m_mod);
        2: exp_dout.push_back(m_slot[sa]);
        default: ;
      endcase
    end

    upper = $urandom & 32'hFFFF_0000;
    cmd = upper | {16'h0, 4'(sb), 4'(sa), 4'(dst), 4'(op)};
    prior = status_seen;
    port1_din = cmd;
    port1_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (port1_read) begin ok = 1'b1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL accept_timeout: got none expected port1_read"); end
    @(posedge clk); #1;
    port1_valid = 1'b0;
    port1_din = $urandom;
    if (op == 0 || op == 3) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      bram_din = N'(data);
      bram_din_valid = 1'b1;
      @(posedge clk); #1;
      bram_din_valid = 1'b0;
      bram_din = N'($urandom);
    end
    if (exp_lat >= 0) begin
      lat = 0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        lat++;
        if (port2_valid) break;
      end
      chk("mul_latency", 32'(lat), 32'(exp_lat));
    end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (status_seen != prior) begin ok = 1'b1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL status_timeout: got none expected status"); end
    @(posedge clk); #1;
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_port1_read"}, {31'h0, port1_read}, 32'h0);
    chk({name, "_port2_valid"}, {31'h0, port2_valid}, 32'h0);
    chk({name, "_port2_dout"}, port2_dout, 32'h0);
    chk({name, "_dout_valid"}, {31'h0, bram_dout_valid}, 32'h0);
    chk({name, "_bram_dout"}, {24'h0, bram_dout}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dst, sa, sb, sel;
    bit ok;
    resetn = 1'b0;
    bram_din = '0;
    bram_din_valid = 1'b0;
    port1_din = '0;
    port1_valid = 1'b0;
    for (int i = 0; i < NS; i++) m_slot[i] = 0;
    m_mod = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    // Known-answer sequence: A = R mod M, so the product echoes B.
    do_cmd(3, 0, 0, 0, 'hEF);
    do_cmd(0, 1, 0, 0, 'h11);
    do_cmd(0, 2, 0, 0, 'h5A);
    do_cmd(1, 3, 1, 2, 0);
    do_cmd(2, 0, 3, 0, 0);
    do_cmd(0, 2, 0, 0, 'hEE);
    do_cmd(1, 2, 1, 2, 0);
    do_cmd(2, 0, 2, 0, 0);

    do_cmd(5, 0, 0, 0, 0);
    do_cmd(2, 0, 1, 0, 0);
    do_cmd(2, 0, 3, 0, 0);

    do_cmd(0, 4, 0, 0, 'h77);
    do_cmd(2, 0, 1, 0, 0);

    do_cmd(3, 0, 0, 0, 'hEE);
    do_cmd(1, 3, 1, 2, 0);
`ifdef MONT_MOD_CHECK_EN
    do_cmd(2, 0, 3, 0, 0);
`else
    do_cmd(0, 3, 0, 0, 'h5A);
`endif

    do_cmd(3, 0, 0, 0, $urandom_range(64, 127) * 2 + 1);
    repeat (40) begin
      sel = $urandom_range(0, 9);
      if (sel <= 2) begin
        dst = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
        do_cmd(0, dst, 0, 0, $urandom_range(0, 255));
      end else if (sel <= 5) begin
        dst = $urandom_range(0, 4);
        sa  = $urandom_range(0, 3);
        sb  = $urandom_range(0, 3);
        if (m_slot[sb] >= m_mod) do_cmd(0, sb, 0, 0, $urandom_range(0, m_mod - 1));
        do_cmd(1, dst, sa, sb, 0);
      end else if (sel <= 7) begin
        sa = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
        do_cmd(2, 0, sa, 0, 0);
      end else if (sel == 8) begin
        do_cmd($urandom_range(4, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 0);
      end else begin
        do_cmd(3, 0, 0, 0, $urandom_range(64, 127) * 2 + 1);
      end
    end

    // Reset in the middle of a multiply: nothing is written, everything clears.
    do_cmd(0, 3, 0, 0, 'h3C);
    port1_din = {16'h0, 4'd2, 4'd1, 4'd3, 4'd1};
    port1_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (port1_read) begin ok = 1'b1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL reset_accept: got none expected port1_read"); end
    @(posedge clk); #1;
    port1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    for (int i = 0; i < NS; i++) m_slot[i] = 0;
    m_mod = 0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    do_cmd(2, 0, 3, 0, 0);

    repeat (5) @(posedge clk);
    chk("status_queue_drained", 32'(exp_st.size()), 32'h0);
    chk("dout_queue_drained", 32'(exp_dout.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
